onehot_decoder_seq: RTL and testbench

ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

---
 rtl/onehot_decoder_pkg.sv | 20 ++
 rtl/onehot_idx_fifo.sv | 52 +++++
 rtl/onehot_decoder_seq.sv | 170 +++++++++++++++++
 tb/tb_onehot_decoder_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_decoder_pkg.sv
// Shared definitions for the one-hot index decoder sequencer.
// Provides the index/output widths, the FSM state encoding and the
// index-to-one-hot decode helper used by the datapath.
package onehot_decoder_pkg;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned OUT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Binary index to one-hot vector
    function automatic logic [OUT_W-1:0] decode(input logic [IDX_W-1:0] idx);
        decode = OUT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/onehot_idx_fifo.sv
// Two-entry index buffer sitting in front of the decoder FSM.
// Only compiled when ONEHOT_DECODER_FIFO_EN is defined.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   push, wr_data write one index (caller guarantees not full)
//   pop           drop the head entry (caller guarantees not empty)
//   rd_data_c     head entry, combinational read
//   level         registered occupancy 0..2
//   level_nx_c    occupancy after this cycle's push/pop
`ifdef ONEHOT_DECODER_FIFO_EN
module onehot_idx_fifo
    import onehot_decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [IDX_W-1:0] wr_data,
    input  logic             pop,
    output logic [IDX_W-1:0] rd_data_c,
    output logic [1:0]       level,
    output logic [1:0]       level_nx_c
);

    logic [IDX_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    assign level_nx_c = level + 2'(push) - 2'(pop);
    assign rd_data_c  = mem[rd_ptr];

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            level <= level_nx_c;
        end
    end

endmodule
`endif

// File: rtl/onehot_decoder_seq.sv
// Sequenced one-hot decoder: each accepted 3-bit index is driven on
// 'onehot' as a single set bit for HOLD_CYCLES cycles, followed by
// GAP_CYCLES zero cycles and one IDLE cycle before the next index.
// Optional feature macro: ONEHOT_DECODER_FIFO_EN adds a 2-entry input
// buffer (onehot_idx_fifo); without it only one index is in flight.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    index offered
//   in_ready    index can be accepted (registered)
//   in_idx      encoded index 0..7
//   onehot      registered decoded output, zero outside DRIVE
//   busy        FSM not idle or buffer non-empty
//   done        pulse on the last DRIVE cycle
module onehot_decoder_seq
    import onehot_decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    output logic [OUT_W-1:0] onehot,
    output logic             busy,
    output logic             done
);

    localparam int unsigned HCNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned GCNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_t            state;
    state_t            state_nx;
    logic [HCNT_W-1:0] hcnt;
    logic [HCNT_W-1:0] hcnt_nx;
    logic [GCNT_W-1:0] gcnt;
    logic [GCNT_W-1:0] gcnt_nx;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_nx;

    logic              accept;
    logic              bypass;
    logic              buf_empty;
    logic [IDX_W-1:0]  buf_idx;
    logic              buf_busy_nx;
    logic              ready_nx;

    logic [OUT_W-1:0]  onehot_d;
    logic              done_d;
    logic              busy_d;

    assign accept = in_valid && in_ready;

`ifdef ONEHOT_DECODER_FIFO_EN
    logic       push;
    logic       pop;
    logic [1:0] level;
    logic [1:0] level_nx;

    // Bypass only when nothing is queued, so acceptance order is preserved
    assign buf_empty   = (level == 2'd0);
    assign bypass      = (state == IDLE) && buf_empty && accept;
    assign pop         = (state == IDLE) && !buf_empty;
    assign push        = accept && !bypass;
    assign buf_busy_nx = (level_nx != 2'd0);
    // Ready reflects occupancy only; a pop in the same cycle does not free a slot early
    assign ready_nx    = (level_nx != 2'd2);

    onehot_idx_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .wr_data    (in_idx),
        .pop        (pop),
        .rd_data_c  (buf_idx),
        .level      (level),
        .level_nx_c (level_nx)
    );
`else
    assign buf_empty   = 1'b1;
    assign buf_idx     = '0;
    assign bypass      = accept;
    assign buf_busy_nx = 1'b0;
    assign ready_nx    = (state_nx == IDLE);
`endif

    // State, counters, held index and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hcnt     <= '0;
            gcnt     <= '0;
            idx_q    <= '0;
            onehot   <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            state    <= state_nx;
            hcnt     <= hcnt_nx;
            gcnt     <= gcnt_nx;
            idx_q    <= idx_nx;
            onehot   <= onehot_d;
            done     <= done_d;
            busy     <= busy_d;
            in_ready <= ready_nx;
        end
    end

    // Next-state: load in IDLE, count down HOLD in DRIVE, count down GAP
    always_comb begin
        state_nx = state;
        hcnt_nx  = hcnt;
        gcnt_nx  = gcnt;
        idx_nx   = idx_q;
        unique case (state)
            IDLE: begin
                if (!buf_empty) begin
                    idx_nx   = buf_idx;
                    hcnt_nx  = HCNT_W'(HOLD_CYCLES);
                    state_nx = DRIVE;
                end else if (bypass) begin
                    idx_nx   = in_idx;
                    hcnt_nx  = HCNT_W'(HOLD_CYCLES);
                    state_nx = DRIVE;
                end
            end
            DRIVE: begin
                if (hcnt == HCNT_W'(1)) begin
                    hcnt_nx = '0;
                    if (GAP_CYCLES > 0) begin
                        gcnt_nx  = GCNT_W'(GAP_CYCLES);
                        state_nx = GAP;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    hcnt_nx = hcnt - HCNT_W'(1);
                end
            end
            GAP: begin
                if (gcnt == GCNT_W'(1)) begin
                    gcnt_nx  = '0;
                    state_nx = IDLE;
                end else begin
                    gcnt_nx = gcnt - GCNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next state
    always_comb begin
        onehot_d = '0;
        done_d   = 1'b0;
        busy_d   = buf_busy_nx;
        if (state_nx == DRIVE) begin
            onehot_d = decode(idx_nx);
            done_d   = (hcnt_nx == HCNT_W'(1));
        end
        if (state_nx != IDLE) begin
            busy_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Self-checking bench for onehot_decoder_seq (default and HOLD=1/GAP=0).
`timescale 1ns/1ps
module tb_onehot_decoder_seq;
    import onehot_decoder_pkg::*;

    localparam int H0 = 4;
    localparam int G0 = 1;
    localparam int H1 = 1;
    localparam int G1 = 0;
`ifdef ONEHOT_DECODER_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v0, r0, b0, d0;
    logic [2:0] i0;
    logic [7:0] o0;
    logic       v1, r1, b1, d1;
    logic [2:0] i1;
    logic [7:0] o1;

    onehot_decoder_seq #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0),
        .in_idx(i0), .onehot(o0), .busy(b0), .done(d0));

    onehot_decoder_seq #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
        .in_idx(i1), .onehot(o1), .busy(b1), .done(d1));

    int checks = 0;
    int errors = 0;
    int sel, mh, mg, cyc, rel_cyc, last_idle;
    bit release_pending;
    // Reference schedule: index, acceptance cycle, first DRIVE cycle
    int q_idx[$];
    int q_acc[$];
    int q_st[$];
    // Observed drive starts
    logic [7:0] obs[$];
    int         obs_c[$];
    logic [7:0] prev_oh;
    logic       prev_done;
    logic [7:0] s_oh;
    logic       s_done, s_busy, s_rdy, s_acc;

    typedef struct { logic [2:0] idx; logic [7:0] oh; } vec_t;
    vec_t tbl[8];
    logic [7:0] e29_oh[6];
    logic       e29_dn[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] m_onehot(input int t);
        foreach (q_st[k])
            if (t >= q_st[k] && t <= q_st[k] + mh - 1) return 8'(1) << q_idx[k];
        return 8'h00;
    endfunction

    function automatic logic m_done(input int t);
        foreach (q_st[k])
            if (t == q_st[k] + mh - 1) return 1'b1;
        return 1'b0;
    endfunction

    // Busy from acceptance until the last GAP cycle of that index
    function automatic logic m_busy(input int t);
        foreach (q_st[k])
            if (t >= q_acc[k] + 1 && t <= q_st[k] + mh + mg - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_ready(input int t);
        int n;
        if (t == rel_cyc) return 1'b0;
        if (!FIFO) return !m_busy(t);
        n = 0;
        foreach (q_st[k])
            if (t >= q_acc[k] + 1 && t <= q_st[k] - 1) n++;
        return n < 2;
    endfunction

    task automatic model_clear();
        q_idx.delete(); q_acc.delete(); q_st.delete();
        obs.delete(); obs_c.delete();
        last_idle = -100000;
        prev_oh = 8'h00;
        prev_done = 1'b0;
    endtask

    // One clock cycle: drive inputs, sample outputs, compare with the model
    task automatic step(input logic v, input logic [2:0] idx);
        logic [7:0] oh;
        logic dn, bs, rd;
        int s;
        @(negedge clk);
        if (sel == 0) begin v0 = v; i0 = idx; v1 = 1'b0; end
        else begin v1 = v; i1 = idx; v0 = 1'b0; end
        if (release_pending) begin
            rst_n = 1'b1;
            rel_cyc = cyc;
            release_pending = 1'b0;
        end
        #1;
        if (sel == 0) begin oh = o0; dn = d0; bs = b0; rd = r0; end
        else begin oh = o1; dn = d1; bs = b1; rd = r1; end
        check("onehot", 32'(oh), 32'(m_onehot(cyc)));
        check("done", 32'(dn), 32'(m_done(cyc)));
        check("busy", 32'(bs), 32'(m_busy(cyc)));
        check("in_ready", 32'(rd), 32'(m_ready(cyc)));
        check("onehot0", 32'($onehot0(oh)), 32'(1));
        check("done_pulse", 32'(dn && prev_done), 32'(0));
        if (oh != 8'h00 && prev_oh == 8'h00) begin
            obs.push_back(oh);
            obs_c.push_back(cyc);
        end
        prev_oh = oh;
        prev_done = dn;
        s_oh = oh; s_done = dn; s_busy = bs; s_rdy = rd;
        s_acc = v && rd;
        if (s_acc) begin
            s = ((last_idle > cyc) ? last_idle : cyc) + 1;
            q_idx.push_back(int'(idx));
            q_acc.push_back(cyc);
            q_st.push_back(s);
            last_idle = s + mh + mg;
        end
        cyc++;
    endtask

    task automatic offer(input logic [2:0] idx);
        int n = 0;
        do begin
            step(1'b1, idx);
            n++;
        end while (!s_acc && n < 40);
        if (!s_acc) begin
            checks++; errors++;
            $display("FAIL offer_timeout idx=%0d actual=not_accepted required=accepted", idx);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin
            step(1'b0, 3'($urandom));
            n++;
        end while ((s_busy || !s_rdy) && n < budget);
        if (s_busy || !s_rdy) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=busy required=idle");
        end
    endtask

    // Asynchronous reset mid-cycle, released at a later negedge by step()
    task automatic do_reset(input int cycles);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_onehot0", 32'(o0), 32'(0));
        check("rst_busy0", 32'(b0), 32'(0));
        check("rst_done0", 32'(d0), 32'(0));
        check("rst_ready0", 32'(r0), 32'(0));
        check("rst_onehot1", 32'(o1), 32'(0));
        check("rst_busy1", 32'(b1), 32'(0));
        check("rst_ready1", 32'(r1), 32'(0));
        model_clear();
        v0 = 1'b0; v1 = 1'b0;
        repeat (cycles) @(negedge clk);
        release_pending = 1'b1;
    endtask

    task automatic single5();
        offer(3'd5);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 3'($urandom));
            check("s029_onehot", 32'(s_oh), 32'(e29_oh[k]));
            check("s029_done", 32'(s_done), 32'(e29_dn[k]));
        end
        check("s029_ready", 32'(s_rdy), 32'(1));
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; i0 = '0; i1 = '0;
        sel = 0; mh = H0; mg = G0; cyc = 0; rel_cyc = -1;
        release_pending = 1'b0;
        model_clear();
        for (int k = 0; k < 8; k++) tbl[k].idx = 3'(k);
        tbl[0].oh = 8'h01; tbl[1].oh = 8'h02; tbl[2].oh = 8'h04; tbl[3].oh = 8'h08;
        tbl[4].oh = 8'h10; tbl[5].oh = 8'h20; tbl[6].oh = 8'h40; tbl[7].oh = 8'h80;
        e29_oh = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
        e29_dn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        #2;
        check("init_onehot", 32'(o0), 32'(0));
        check("init_busy", 32'(b0), 32'(0));
        check("init_ready", 32'(r0), 32'(0));
        repeat (3) @(negedge clk);
        release_pending = 1'b1;

        // Table: each index decodes to its one-hot, one cycle after acceptance
        for (int k = 0; k < 8; k++) begin
            offer(tbl[k].idx);
            step(1'b0, 3'($urandom));
            check("tbl_onehot", 32'(s_oh), 32'(tbl[k].oh));
            drain(40);
        end

        // Single index timing
        single5();
        drain(40);

        // Valid held high on one index
        obs.delete(); obs_c.delete();
        for (int k = 0; k < 14; k++) begin
            step(1'b1, 3'd2);
            if (k == 1) check("s031_ready_c1", 32'(s_rdy), 32'(FIFO ? 1 : 0));
        end
        check("s031_drives", 32'(obs.size()), 32'(3));
        foreach (obs[k]) check("s031_value", 32'(obs[k]), 32'(8'h04));
        drain(40);

        // Back-to-back indices keep order and spacing
        obs.delete(); obs_c.delete();
        offer(3'd0); offer(3'd7); offer(3'd3);
        drain(60);
        check("s030_count", 32'(obs.size()), 32'(3));
        if (obs.size() == 3) begin
            check("s030_first", 32'(obs[0]), 32'(8'h01));
            check("s030_second", 32'(obs[1]), 32'(8'h80));
            check("s030_third", 32'(obs[2]), 32'(8'h08));
            check("s030_space", 32'(obs_c[2] - obs_c[1]), 32'(6));
        end

        // Reset on the second DRIVE cycle, then a clean restart
        step(1'b1, 3'd5);
        step(1'b1, 3'd7);
        step(1'b0, 3'd0);
        check("s033_pre", 32'(s_oh), 32'(8'h20));
        do_reset(2);
        single5();
        drain(40);
        check("s033_no_stale", 32'(obs.size()), 32'(1));

        // Random traffic on the default instance
        for (int k = 0; k < 500; k++) step(1'($urandom), 3'($urandom));
        drain(40);

        // HOLD=1, GAP=0 instance
        sel = 1; mh = H1; mg = G1;
        do_reset(2);
        offer(3'd1); offer(3'd6);
        drain(20);
        check("s032_count", 32'(obs.size()), 32'(2));
        if (obs.size() == 2) begin
            check("s032_first", 32'(obs[0]), 32'(8'h02));
            check("s032_second", 32'(obs[1]), 32'(8'h40));
            check("s032_space", 32'(obs_c[1] - obs_c[0]), 32'(2));
        end
        for (int k = 0; k < 300; k++) step(1'($urandom), 3'($urandom));
        drain(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
